lot_occupancy_ctrl: RTL and testbench

- Controller that sequences the lot's saturating up/down occupancy counter (0..16).
- Watches two gate photo-sensors (a = outer, b = inner), decodes complete car-entry and car-exit sequences, and issues single-cycle incr/decr commands to the counter.
- Reads the counter value back to drive full/empty status and to refuse increments at capacity.
- Sits between the raw sensor pins and the counter; all outputs are registered.

---
 rtl/lot_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/lot_occupancy_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lot_occupancy_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lot_pkg.sv
// Shared types and defaults for the parking-lot gate controller.
// Gate sequencing states and default sizing of the occupancy counter.
package lot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN1   = 3'd1,
        EN2   = 3'd2,
        EN3   = 3'd3,
        EX1   = 3'd4,
        EX2   = 3'd5,
        EX3   = 3'd6,
        FAULT = 3'd7
    } gate_state_t;

    localparam int CAP_DEFAULT   = 16;
    localparam int WIDTH_DEFAULT = 5;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
// Depth is clamped to at least two flops.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] r_sync;

    // Shift chain: the raw input enters at bit 0 and leaves at the top bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {N{1'b0}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Gate sensor sequencer: decodes full entry/exit passages from the two beams
// and issues incr/decr commands to the occupancy counter, with full/empty status.
module lot_occupancy_ctrl
    import lot_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int CAP         = CAP_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic [WIDTH-1:0] count,
    output logic             incr,
    output logic             decr,
    output logic             full,
    output logic             empty,
    output logic             rej,
    output logic             err
);

    localparam logic [WIDTH-1:0] CAP_W  = WIDTH'(CAP);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic        w_as;
    logic        w_bs;
    logic [1:0]  w_ab;
    logic        w_at_cap;
    logic        w_nonzero;

    gate_state_t r_state;
    gate_state_t w_next;
    logic        w_incr;
    logic        w_decr;
    logic        w_rej;
    logic        w_err;

    logic        r_incr;
    logic        r_decr;
    logic        r_rej;
    logic        r_err;
    logic        r_full;
    logic        r_empty;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (a),
        .o_q     (w_as)
    );

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (b),
        .o_q     (w_bs)
    );

    assign w_ab      = {w_as, w_bs};
    assign w_at_cap  = (count >= CAP_W);
    assign w_nonzero = (count != ZERO_W);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and command pulses; any unlisted input holds the state
    always_comb begin
        w_next = r_state;
        w_incr = 1'b0;
        w_decr = 1'b0;
        w_rej  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: begin
                case (w_ab)
                    2'b10:   w_next = EN1;
                    2'b01:   w_next = EX1;
                    2'b11: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = IDLE;
                endcase
            end
            EN1: begin
                case (w_ab)
                    2'b11:   w_next = EN2;
                    2'b00:   w_next = IDLE;
                    2'b01: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EN1;
                endcase
            end
            EN2: begin
                case (w_ab)
                    2'b01:   w_next = EN3;
                    2'b10:   w_next = EN1;
                    2'b00: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EN2;
                endcase
            end
            EN3: begin
                case (w_ab)
                    2'b00: begin
                        w_next = IDLE;
                        if (w_at_cap) begin
                            w_rej = 1'b1;
                        end else begin
                            w_incr = 1'b1;
                        end
                    end
                    2'b11:   w_next = EN2;
                    2'b10: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EN3;
                endcase
            end
            EX1: begin
                case (w_ab)
                    2'b11:   w_next = EX2;
                    2'b00:   w_next = IDLE;
                    2'b10: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EX1;
                endcase
            end
            EX2: begin
                case (w_ab)
                    2'b10:   w_next = EX3;
                    2'b01:   w_next = EX1;
                    2'b00: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EX2;
                endcase
            end
            EX3: begin
                case (w_ab)
                    2'b00: begin
                        w_next = IDLE;
                        // An exit from an empty lot finishes silently
                        if (w_nonzero) begin
                            w_decr = 1'b1;
                        end else begin
                            w_decr = 1'b0;
                        end
                    end
                    2'b11:   w_next = EX2;
                    2'b01: begin
                        w_next = FAULT;
                        w_err  = 1'b1;
                    end
                    default: w_next = EX3;
                endcase
            end
            FAULT: begin
                if (w_ab == 2'b00) begin
                    w_next = IDLE;
                end else begin
                    w_next = FAULT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered command pulses and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_incr  <= 1'b0;
            r_decr  <= 1'b0;
            r_rej   <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_incr  <= w_incr;
            r_decr  <= w_decr;
            r_rej   <= w_rej;
            r_err   <= w_err;
            r_full  <= w_at_cap;
            r_empty <= ~w_nonzero;
        end
    end

    assign incr  = r_incr;
    assign decr  = r_decr;
    assign rej   = r_rej;
    assign err   = r_err;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: tb/tb_lot_occupancy_ctrl.sv
// Directed bench for lot_occupancy_ctrl: scenario tasks with hand-computed
// expectations, pulse counting on the falling edge.
module tb_lot_occupancy_ctrl;
    import lot_pkg::*;

    logic       clk;
    logic       reset;
    logic       a;
    logic       b;
    logic [4:0] count;
    logic       incr;
    logic       decr;
    logic       full;
    logic       empty;
    logic       rej;
    logic       err;

    int checks;
    int errors;
    int n_incr;
    int n_decr;
    int n_rej;
    int n_err;
    int n_overlap;

    int s_incr;
    int s_decr;
    int s_rej;
    int s_err;

    lot_occupancy_ctrl #(.WIDTH(5), .CAP(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .count (count),
        .incr  (incr),
        .decr  (decr),
        .full  (full),
        .empty (empty),
        .rej   (rej),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (incr) n_incr++;
        if (decr) n_decr++;
        if (rej)  n_rej++;
        if (err)  n_err++;
        if ((int'(incr) + int'(decr) + int'(rej) + int'(err)) > 1) n_overlap++;
    end

    task automatic apply(input logic [1:0] ab, input int n);
        a = ab[1];
        b = ab[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_incr = n_incr;
        s_decr = n_decr;
        s_rej  = n_rej;
        s_err  = n_err;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a = 1'b0;
        b = 1'b0;
        count = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({incr, decr, rej, err, full, empty} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_hold: got %b required 000001", {incr, decr, rej, err, full, empty});
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({incr, decr, rej, err, full, empty} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_release: got %b required 000001", {incr, decr, rej, err, full, empty});
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.r_state, IDLE);
        end
    endtask

    task automatic test_entry();
        count = 5'd3;
        snap();
        apply(2'b10, 4);
        apply(2'b11, 4);
        apply(2'b01, 4);
        a = 1'b0;
        b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (incr !== 1'b0) begin
            errors++;
            $display("FAIL entry_early: incr got %b required 0", incr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (incr !== 1'b1) begin
            errors++;
            $display("FAIL entry_latency: incr got %b required 1", incr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (incr !== 1'b0) begin
            errors++;
            $display("FAIL entry_width: incr got %b required 0", incr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ((n_incr - s_incr) !== 1 || (n_decr - s_decr) !== 0 || (n_rej - s_rej) !== 0 || (n_err - s_err) !== 0) begin
            errors++;
            $display("FAIL entry_counts: incr/decr/rej/err got %0d/%0d/%0d/%0d required 1/0/0/0",
                     n_incr - s_incr, n_decr - s_decr, n_rej - s_rej, n_err - s_err);
        end
    endtask

    task automatic test_exit();
        count = 5'd5;
        snap();
        apply(2'b01, 4);
        apply(2'b11, 4);
        apply(2'b10, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_decr - s_decr) !== 1 || (n_incr - s_incr) !== 0 || (n_err - s_err) !== 0) begin
            errors++;
            $display("FAIL exit_counts: decr/incr/err got %0d/%0d/%0d required 1/0/0",
                     n_decr - s_decr, n_incr - s_incr, n_err - s_err);
        end
        count = 5'd0;
        snap();
        apply(2'b01, 4);
        apply(2'b11, 4);
        apply(2'b10, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_decr - s_decr) !== 0 || (n_err - s_err) !== 0 || (n_incr - s_incr) !== 0) begin
            errors++;
            $display("FAIL exit_empty: decr/err/incr got %0d/%0d/%0d required 0/0/0",
                     n_decr - s_decr, n_err - s_err, n_incr - s_incr);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL exit_empty_flag: empty got %b required 1", empty);
        end
    endtask

    task automatic test_reversal();
        count = 5'd4;
        snap();
        apply(2'b10, 4);
        apply(2'b11, 4);
        apply(2'b10, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_incr + n_decr + n_rej + n_err) !== (s_incr + s_decr + s_rej + s_err)) begin
            errors++;
            $display("FAIL reversal_pulses: got %0d pulses required 0",
                     (n_incr + n_decr + n_rej + n_err) - (s_incr + s_decr + s_rej + s_err));
        end
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reversal_state: got %0d required %0d", dut.r_state, IDLE);
        end
        snap();
        apply(2'b01, 4);
        apply(2'b11, 4);
        apply(2'b01, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_incr + n_decr + n_rej + n_err) !== (s_incr + s_decr + s_rej + s_err)) begin
            errors++;
            $display("FAIL partial_exit_pulses: got %0d pulses required 0",
                     (n_incr + n_decr + n_rej + n_err) - (s_incr + s_decr + s_rej + s_err));
        end
    endtask

    task automatic test_full();
        count = 5'd16;
        repeat (2) @(negedge clk);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: full/empty got %b%b required 10", full, empty);
        end
        snap();
        apply(2'b10, 4);
        apply(2'b11, 4);
        apply(2'b01, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_rej - s_rej) !== 1 || (n_incr - s_incr) !== 0) begin
            errors++;
            $display("FAIL full_reject: rej/incr got %0d/%0d required 1/0", n_rej - s_rej, n_incr - s_incr);
        end
        count = 5'd15;
        repeat (2) @(negedge clk);
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL below_cap_flag: full got %b required 0", full);
        end
        snap();
        apply(2'b10, 4);
        apply(2'b11, 4);
        apply(2'b01, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_incr - s_incr) !== 1 || (n_rej - s_rej) !== 0) begin
            errors++;
            $display("FAIL below_cap_entry: incr/rej got %0d/%0d required 1/0", n_incr - s_incr, n_rej - s_rej);
        end
    endtask

    task automatic test_illegal();
        count = 5'd3;
        snap();
        apply(2'b11, 6);
        checks++;
        if ((n_err - s_err) !== 1) begin
            errors++;
            $display("FAIL illegal_err: err got %0d pulses required 1", n_err - s_err);
        end
        snap();
        apply(2'b10, 4);
        apply(2'b01, 4);
        checks++;
        if ((n_incr + n_decr + n_rej + n_err) !== (s_incr + s_decr + s_rej + s_err)) begin
            errors++;
            $display("FAIL fault_silent: got %0d pulses required 0",
                     (n_incr + n_decr + n_rej + n_err) - (s_incr + s_decr + s_rej + s_err));
        end
        apply(2'b00, 4);
        checks++;
        if (dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL fault_exit: state got %0d required %0d", dut.r_state, IDLE);
        end
        snap();
        apply(2'b10, 4);
        apply(2'b11, 4);
        apply(2'b01, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_incr - s_incr) !== 1 || (n_err - s_err) !== 0) begin
            errors++;
            $display("FAIL post_fault_entry: incr/err got %0d/%0d required 1/0", n_incr - s_incr, n_err - s_err);
        end
    endtask

    task automatic test_async_reset();
        count = 5'd16;
        apply(2'b00, 2);
        apply(2'b10, 4);
        apply(2'b11, 4);
        checks++;
        if (dut.r_state !== EN2 || full !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: state/full got %0d/%b required %0d/1", dut.r_state, full, EN2);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        a = 1'b0;
        b = 1'b1;
        #1;
        checks++;
        if ({incr, decr, rej, err, full, empty} !== 6'b000001 || dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: outputs got %b state %0d required 000001 state %0d",
                     {incr, decr, rej, err, full, empty}, dut.r_state, IDLE);
        end
        count = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        snap();
        apply(2'b01, 4);
        apply(2'b00, 6);
        checks++;
        if ((n_incr + n_decr + n_rej + n_err) !== (s_incr + s_decr + s_rej + s_err)) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d pulses required 0",
                     (n_incr + n_decr + n_rej + n_err) - (s_incr + s_decr + s_rej + s_err));
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_overlap !== 0) begin
            errors++;
            $display("FAIL exclusive_pulses: got %0d overlapping cycles required 0", n_overlap);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_incr    = 0;
        n_decr    = 0;
        n_rej     = 0;
        n_err     = 0;
        n_overlap = 0;
        test_reset();
        test_entry();
        test_exit();
        test_reversal();
        test_full();
        test_illegal();
        test_async_reset();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
